// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - handshaked EX->WB memory stage driving a split-transaction data SRAM port
// Holds one instruction; issues at most one request and drains a late response after flush.
module mem_stage_hs #(
  parameter int PC_W   = 32,
  parameter int RF_AW  = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [3:0]        ex_mop,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_rf_we,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  input  logic [31:0]       ex_result,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [31:0]       wb_rf_wdata,
  output logic              wb_exc_ale,
  output logic              fwd_we,
  output logic [RF_AW-1:0]  fwd_waddr,
  output logic [31:0]       fwd_wdata,
  output logic              fwd_pending
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [3:0]        mop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, res_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        size_q;
  logic              wr_q, load_q, rf_we_q, ale_q;
  logic [RF_AW-1:0]  waddr_q;

  logic        dec_load, dec_store, dec_mem, dec_mis;
  logic [1:0]  dec_size;
  logic [3:0]  dec_wstrb;
  logic [31:0] dec_wdata, shifted, ld_val;
  logic        accept, resp_done, capture;

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_size  = 2'd0;
    case (ex_mop)
      4'd1, 4'd2: begin dec_load = 1'b1;  dec_size = 2'd0; end
      4'd3, 4'd4: begin dec_load = 1'b1;  dec_size = 2'd1; end
      4'd5:       begin dec_load = 1'b1;  dec_size = 2'd2; end
      4'd6:       begin dec_store = 1'b1; dec_size = 2'd0; end
      4'd7:       begin dec_store = 1'b1; dec_size = 2'd1; end
      4'd8:       begin dec_store = 1'b1; dec_size = 2'd2; end
      default:    ;
    endcase
    dec_mem = dec_load | dec_store;
    dec_mis = dec_mem && ((dec_size == 2'd1 && ex_addr[0]) ||
                          (dec_size == 2'd2 && ex_addr[1:0] != 2'b00));
    dec_wstrb = 4'b0000;
    if (dec_store) begin
      case (dec_size)
        2'd0:    dec_wstrb = 4'b0001 << ex_addr[1:0];
        2'd1:    dec_wstrb = 4'b0011 << ex_addr[1:0];
        default: dec_wstrb = 4'b1111;
      endcase
    end
    case (dec_size)
      2'd0:    dec_wdata = {4{ex_wdata[7:0]}};
      2'd1:    dec_wdata = {2{ex_wdata[15:0]}};
      default: dec_wdata = ex_wdata;
    endcase
  end

  always_comb begin
    shifted = data_rdata >> {addr_q[1:0], 3'b000};
    case (mop_q)
      4'd1:    ld_val = {{24{shifted[7]}}, shifted[7:0]};
      4'd2:    ld_val = {24'd0, shifted[7:0]};
      4'd3:    ld_val = {{16{shifted[15]}}, shifted[15:0]};
      4'd4:    ld_val = {16'd0, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  assign accept    = ex_valid & ex_ready;
  // A response in REQ only counts when it rides along with addr_ok.
  assign resp_done = data_data_ok &&
                     (state_q == S_WAIT || (state_q == S_REQ && data_addr_ok));
  assign capture   = resp_done & load_q & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      mop_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      load_q  <= 1'b0;
      rf_we_q <= 1'b0;
      ale_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q    <= ex_pc;
        mop_q   <= ex_mop;
        addr_q  <= ex_addr;
        wdata_q <= dec_wdata;
        res_q   <= ex_result;
        wstrb_q <= dec_wstrb;
        size_q  <= dec_size;
        wr_q    <= dec_store;
        load_q  <= dec_load;
        rf_we_q <= ex_rf_we & ~dec_store & ~dec_mis;
        ale_q   <= dec_mis;
        waddr_q <= ex_rf_waddr;
      end else if (capture) begin
        res_q <= ld_val;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (flush) state_d = S_IDLE;
        else if (accept) state_d = (!dec_mem || dec_mis) ? S_DONE : S_REQ;
        else if (state_q == S_DONE && wb_ready) state_d = S_IDLE;
      end
      S_REQ: begin
        if (flush) state_d = (!data_addr_ok || data_data_ok) ? S_IDLE : S_DRAIN;
        else if (data_addr_ok) state_d = data_data_ok ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (flush) state_d = data_data_ok ? S_IDLE : S_DRAIN;
        else if (data_data_ok) state_d = S_DONE;
      end
      S_DRAIN: if (data_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ex_ready    = ~flush && (state_q == S_IDLE || (state_q == S_DONE && wb_ready));
    data_req    = (state_q == S_REQ);
    data_wr     = data_req & wr_q;
    data_size   = data_req ? size_q : 2'd0;
    data_wstrb  = data_req ? wstrb_q : 4'd0;
    data_addr   = data_req ? addr_q : '0;
    data_wdata  = data_req ? wdata_q : 32'd0;
    wb_valid    = (state_q == S_DONE);
    wb_pc       = wb_valid ? pc_q : '0;
    wb_rf_we    = wb_valid & rf_we_q;
    wb_rf_waddr = wb_valid ? waddr_q : '0;
    wb_rf_wdata = wb_valid ? res_q : 32'd0;
    wb_exc_ale  = wb_valid & ale_q;
    fwd_we      = wb_valid & rf_we_q;
    fwd_waddr   = waddr_q;
    fwd_wdata   = res_q;
    fwd_pending = (state_q == S_REQ || state_q == S_WAIT) & load_q & rf_we_q;
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - randomized and directed self-checking bench for mem_stage_hs
module tb_mem_stage_hs;
  logic        clk = 1'b0;
  logic        rst, flush, ex_valid, ex_ready, ex_rf_we;
  logic [31:0] ex_pc, ex_addr, ex_wdata, ex_result;
  logic [3:0]  ex_mop;
  logic [4:0]  ex_rf_waddr;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        wb_valid, wb_ready, wb_rf_we, wb_exc_ale, fwd_we, fwd_pending;
  logic [31:0] wb_pc, wb_rf_wdata, fwd_wdata;
  logic [4:0]  wb_rf_waddr, fwd_waddr;

  int vectors = 0;
  int miscompares = 0;

  // Observations collected by do_op for the test tasks to judge.
  logic        o_acc, o_req_seen, o_stable, o_pend, o_wr, o_we, o_ale;
  logic [1:0]  o_size;
  logic [3:0]  o_strb;
  logic [31:0] o_addr, o_wdata, o_wd, o_pc;
  int          o_lat;

  mem_stage_hs #(.PC_W(32), .RF_AW(5), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_mop(ex_mop), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .wb_exc_ale(wb_exc_ale), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [3:0] m);
    case (m)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] m, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (m)
      4'd1:    return ((v & 255) >= 128) ? (v & 255) + 32'hFFFF_FF00 : (v & 255);
      4'd2:    return v & 255;
      4'd3:    return ((v & 65535) >= 32768) ? (v & 65535) + 32'hFFFF_0000 : (v & 65535);
      4'd4:    return v & 65535;
      default: return v;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] mop, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] result, input logic rfwe, input logic [31:0] pc,
                       input int aok_dly, input int dok_dly, input logic [31:0] rdata);
    int cyc, req_cyc, aok_at;
    ex_valid = 1'b1; ex_mop = mop; ex_addr = addr; ex_wdata = wdata; ex_result = result;
    ex_rf_we = rfwe; ex_rf_waddr = 5'd7; ex_pc = pc; wb_ready = 1'b1;
    #1;
    o_acc = ex_ready;
    tick();
    ex_valid = 1'b0;
    cyc = 1; req_cyc = 0; aok_at = -1;
    o_req_seen = 1'b0; o_stable = 1'b1; o_pend = 1'b0; o_lat = -1;
    while (cyc < 60 && o_lat < 0) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      if (data_req) begin
        if (!o_req_seen) begin
          o_wr = data_wr; o_size = data_size; o_strb = data_wstrb;
          o_addr = data_addr; o_wdata = data_wdata;
        end else if (o_wr !== data_wr || o_size !== data_size || o_strb !== data_wstrb ||
                     o_addr !== data_addr || o_wdata !== data_wdata) begin
          o_stable = 1'b0;
        end
        o_req_seen = 1'b1;
        if (req_cyc == aok_dly) begin
          data_addr_ok = 1'b1;
          aok_at = cyc;
        end
        req_cyc++;
      end
      if (aok_at >= 0 && cyc == aok_at + dok_dly) begin
        data_data_ok = 1'b1;
        data_rdata = rdata;
      end
      if (fwd_pending) o_pend = 1'b1;
      if (wb_valid) begin
        o_lat = cyc; o_we = wb_rf_we; o_ale = wb_exc_ale; o_wd = wb_rf_wdata; o_pc = wb_pc;
      end
      tick();
      cyc++;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ex_ready got %0b want 1", ex_ready); end
    vectors++;
    if ({data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata} !== '0) begin
      miscompares++; $display("FAIL reset_data_side got req=%0b addr=%h wstrb=%b want all 0", data_req, data_addr, data_wstrb);
    end
    vectors++;
    if ({wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata, wb_exc_ale, fwd_we, fwd_waddr, fwd_wdata, fwd_pending} !== '0) begin
      miscompares++; $display("FAIL reset_wb_fwd got wb_valid=%0b wdata=%h fwd_pending=%0b want all 0", wb_valid, wb_rf_wdata, fwd_pending);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed_ops();
    do_op(4'd3, 32'h1002, 32'h0, 32'h0, 1'b1, 32'h100, 0, 1, 32'h8001_7FFF);
    vectors++; if (o_size !== 2'd1) begin miscompares++; $display("FAIL lh_size got %0d want 1", o_size); end
    vectors++; if (o_wd !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_data got %h want ffff8001", o_wd); end
    vectors++; if (o_lat !== 3) begin miscompares++; $display("FAIL lh_latency got %0d want 3", o_lat); end
    do_op(4'd6, 32'h2003, 32'h0000_00A5, 32'h0, 1'b1, 32'h104, 1, 0, 32'h0);
    vectors++; if (o_strb !== 4'b1000) begin miscompares++; $display("FAIL sb_strb got %b want 1000", o_strb); end
    vectors++; if (o_wdata !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL sb_wdata got %h want a5a5a5a5", o_wdata); end
    vectors++; if (o_wr !== 1'b1 || o_we !== 1'b0) begin miscompares++; $display("FAIL sb_wr_rfwe got wr=%0b rf_we=%0b want 1/0", o_wr, o_we); end
    do_op(4'd5, 32'h3002, 32'h0, 32'h0, 1'b1, 32'h108, 0, 1, 32'h0);
    vectors++; if (o_req_seen !== 1'b0) begin miscompares++; $display("FAIL lw_mis_req got %0b want 0", o_req_seen); end
    vectors++; if (o_ale !== 1'b1 || o_we !== 1'b0 || o_lat !== 1) begin
      miscompares++; $display("FAIL lw_mis_wb got ale=%0b rf_we=%0b lat=%0d want 1/0/1", o_ale, o_we, o_lat);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  mop;
      logic [31:0] addr, wd, res, rd, pc;
      logic        rfwe, ld, st, mis;
      logic [1:0]  esize;
      int          n, aok, dok, elat;
      mop = 4'($urandom_range(0, 15));
      addr = $urandom; wd = $urandom; res = $urandom; rd = $urandom; pc = $urandom;
      rfwe = 1'($urandom); aok = $urandom_range(0, 3); dok = $urandom_range(0, 3);
      n = nbytes(mop);
      if (n > 1 && $urandom_range(0, 3) != 0) addr = addr - (addr % n);
      ld = (mop >= 1 && mop <= 5);
      st = (mop >= 6 && mop <= 8);
      mis = (n > 1) && (addr % n != 0);
      esize = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
      elat = (n == 0 || mis) ? 1 : 2 + aok + dok;
      do_op(mop, addr, wd, res, rfwe, pc, aok, dok, rd);
      vectors++; if (o_acc !== 1'b1) begin miscompares++; $display("FAIL rnd_accept op=%0d got %0b want 1", mop, o_acc); end
      vectors++; if (o_lat !== elat) begin miscompares++; $display("FAIL rnd_latency op=%0d got %0d want %0d", mop, o_lat, elat); end
      vectors++; if (o_req_seen !== (n != 0 && !mis)) begin miscompares++; $display("FAIL rnd_req op=%0d got %0b want %0b", mop, o_req_seen, (n != 0 && !mis)); end
      if (n != 0 && !mis) begin
        vectors++;
        if (o_wr !== st || o_size !== esize || o_addr !== addr || o_stable !== 1'b1) begin
          miscompares++; $display("FAIL rnd_req_fields op=%0d got wr=%0b size=%0d addr=%h stable=%0b want %0b/%0d/%h/1", mop, o_wr, o_size, o_addr, o_stable, st, esize, addr);
        end
        vectors++;
        if (o_strb !== (st ? 4'(((1 << n) - 1) << (addr % 4)) : 4'b0000)) begin
          miscompares++; $display("FAIL rnd_strb op=%0d got %b want %b", mop, o_strb, st ? 4'(((1 << n) - 1) << (addr % 4)) : 4'b0000);
        end
        if (st) begin
          vectors++;
          if (o_wdata !== ((n == 1) ? (wd & 255) * 32'h0101_0101 : (n == 2) ? (wd & 65535) * 32'h0001_0001 : wd)) begin
            miscompares++; $display("FAIL rnd_wdata op=%0d got %h", mop, o_wdata);
          end
        end
      end
      vectors++;
      if (o_we !== (rfwe && !st && !mis) || o_ale !== mis || o_pc !== pc) begin
        miscompares++; $display("FAIL rnd_wb_ctrl op=%0d got we=%0b ale=%0b pc=%h want %0b/%0b/%h", mop, o_we, o_ale, o_pc, (rfwe && !st && !mis), mis, pc);
      end
      vectors++; if (o_pend !== (ld && !mis && rfwe)) begin miscompares++; $display("FAIL rnd_pending op=%0d got %0b want %0b", mop, o_pend, (ld && !mis && rfwe)); end
      if (!mis) begin
        vectors++;
        if (o_wd !== (ld ? ref_load(mop, addr, rd) : res)) begin
          miscompares++; $display("FAIL rnd_wb_data op=%0d got %h want %h", mop, o_wd, ld ? ref_load(mop, addr, rd) : res);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; ex_mop = 4'd2; ex_addr = 32'h11; ex_rf_we = 1'b1; ex_rf_waddr = 5'd3;
    ex_result = 32'h0; wb_ready = 1'b1;
    #1;
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got %0b want 1", ex_ready); end
    tick();
    ex_mop = 4'd0; ex_result = 32'h1234; ex_rf_waddr = 5'd4; data_addr_ok = 1'b1;
    #1;
    vectors++; if (fwd_pending !== 1'b1 || ex_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_req got pending=%0b ready=%0b want 1/0", fwd_pending, ex_ready); end
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_C300;
    vectors++; if (fwd_pending !== 1'b1) begin miscompares++; $display("FAIL b2b_wait_pending got %0b want 1", fwd_pending); end
    tick();
    data_data_ok = 1'b0;
    #1;
    vectors++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h0000_00C3 || ex_ready !== 1'b1 || fwd_we !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first got valid=%0b data=%h ready=%0b fwd_we=%0b want 1/000000c3/1/1", wb_valid, wb_rf_wdata, ex_ready, fwd_we);
    end
    tick();
    ex_valid = 1'b0;
    vectors++; if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h0000_1234 || wb_rf_waddr !== 5'd4) begin
      miscompares++; $display("FAIL b2b_second got valid=%0b data=%h waddr=%0d want 1/00001234/4", wb_valid, wb_rf_wdata, wb_rf_waddr);
    end
    tick();
  endtask

  task automatic test_flush();
    ex_valid = 1'b1; ex_mop = 4'd5; ex_addr = 32'h40; ex_rf_we = 1'b1; ex_result = 32'h55; wb_ready = 1'b1;
    tick();
    ex_valid = 1'b0; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %0b want 0", ex_ready); end
    tick();
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; end
      #1;
      vectors++;
      if (ex_ready !== 1'b0 || wb_valid !== 1'b0 || data_req !== 1'b0 || fwd_pending !== 1'b0) begin
        miscompares++; $display("FAIL drain_c%0d got ready=%0b valid=%0b req=%0b pend=%0b want 0", c, ex_ready, wb_valid, data_req, fwd_pending);
      end
      tick();
    end
    data_data_ok = 1'b0;
    vectors++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || fwd_we !== 1'b0) begin
      miscompares++; $display("FAIL drain_exit got ready=%0b valid=%0b fwd_we=%0b want 1/0/0", ex_ready, wb_valid, fwd_we);
    end
    ex_valid = 1'b1; ex_mop = 4'd8; ex_addr = 32'h80;
    tick();
    ex_valid = 1'b0; flush = 1'b1;
    vectors++; if (data_req !== 1'b1) begin miscompares++; $display("FAIL flush_req_before got %0b want 1", data_req); end
    tick();
    flush = 1'b0;
    #1;
    vectors++; if (data_req !== 1'b0 || ex_ready !== 1'b1) begin miscompares++; $display("FAIL flush_req_withdraw got req=%0b ready=%0b want 0/1", data_req, ex_ready); end
    tick();
  endtask

  task automatic test_stall_reset();
    ex_valid = 1'b1; ex_mop = 4'd7; ex_addr = 32'h106; ex_wdata = 32'h1234_BEEF; ex_rf_we = 1'b1; wb_ready = 1'b1;
    tick();
    ex_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (data_req !== 1'b1 || data_addr !== 32'h106 || data_wstrb !== 4'b1100 || data_wdata !== 32'hBEEF_BEEF || ex_ready !== 1'b0) begin
        miscompares++; $display("FAIL stall_c%0d got req=%0b addr=%h strb=%b wdata=%h ready=%0b", c, data_req, data_addr, data_wstrb, data_wdata, ex_ready);
      end
      tick();
    end
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (ex_ready !== 1'b1 || {data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        wb_valid, wb_rf_we, wb_exc_ale, fwd_we, fwd_pending, fwd_wdata} !== '0) begin
      miscompares++; $display("FAIL reset_in_wait got ready=%0b req=%0b valid=%0b fwd_wdata=%h want ready=1 rest 0", ex_ready, data_req, wb_valid, fwd_wdata);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_mop = '0; ex_addr = '0;
    ex_wdata = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; wb_ready = 1'b0;
    #1;
    test_reset();
    test_directed_ops();
    test_back_to_back();
    test_flush();
    test_random();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Handshaked memory-access pipeline stage between EX and WB, driving a split-transaction data SRAM interface (request, address-accept, data-return). It holds one instruction at a time. It generates byte strobes and lane-replicated store data, and extracts and extends load data by address offset. It detects misaligned accesses, supports flush with draining of an outstanding response, and provides forwarding plus a load-pending signal to ID.

Parameters:
PC_W, 32, width of the pc field carried to WB
RF_AW, 5, register-file address width
ADDR_W, 32, data address width; must be at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill the held instruction
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  stage can accept this cycle
ex_pc  in  PC_W  instruction pc
ex_mop  in  4  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw; 9-15 treated as none
ex_addr  in  ADDR_W  effective address
ex_wdata  in  32  store source register value
ex_rf_we  in  1  writeback enable
ex_rf_waddr  in  RF_AW  writeback register
ex_result  in  32  ALU result for non-load instructions
data_req  out  1  request valid
data_wr  out  1  1 = store
data_size  out  2  0 byte, 1 half, 2 word
data_wstrb  out  4  byte strobes; 0 for loads
data_addr  out  ADDR_W  request address
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response returned (read data or write ack)
data_rdata  in  32  read data
wb_valid  out  1  result available to WB
wb_ready  in  1  WB accepts
wb_pc  out  PC_W  pc of the result
wb_rf_we  out  1  writeback enable
wb_rf_waddr  out  RF_AW  writeback register
wb_rf_wdata  out  32  writeback data
wb_exc_ale  out  1  address-alignment exception
fwd_we  out  1  forwarding value valid
fwd_waddr  out  RF_AW  forwarding register
fwd_wdata  out  32  forwarding data
fwd_pending  out  1  held load has a write to fwd_waddr whose data is not yet available; ID must stall on a match

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset: IDLE, all held fields cleared, every output 0, except ex_ready=1.
- ex_ready = (IDLE) or (DONE and wb_ready). It is 0 in REQ, WAIT and DRAIN, and 0 whenever flush=1.
- Accept when ex_valid and ex_ready. The next state is decided by the accepted op:
  - none: DONE.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): DONE with exc_ale=1 and rf_we forced 0. No request is issued.
  - Otherwise: REQ.
- REQ: data_req=1; all request fields are registered and stable.
  - addr_ok=1 leads to WAIT.
  - data_ok in the same cycle as addr_ok is legal. It is treated as a WAIT completion, so the next state is DONE.
- WAIT: data_ok leads to DONE. On a load, data_rdata is captured that cycle.
- DONE: wb_valid=1. Leaving on wb_ready goes to IDLE, or directly into the next op if a new instruction is accepted the same cycle (back-to-back).
- Latency, accept cycle N:
  - Non-memory op: wb_valid at N+1.
  - Memory op with addr_ok at N+1 and data_ok at N+2: wb_valid at N+3.
- Store strobes and data:
  - sb: strobe 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - sh: strobe 0011<<addr[1:0], data {2{wdata[15:0]}}.
  - sw: strobe 1111, data = wdata.
- Load extract: shifted = rdata >> (8*addr[1:0]).
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes shifted unchanged.
- wb_rf_wdata = extracted load data for loads, ex_result otherwise. Stores force rf_we to 0.
- Forwarding:
  - fwd_we = DONE and rf_we.
  - fwd_waddr and fwd_wdata always reflect the held instruction.
  - fwd_pending = (REQ or WAIT) and the op is a load and rf_we.
- Flush overrides accept:
  - In IDLE or DONE: go to IDLE.
  - In REQ without addr_ok: withdraw the request, go to IDLE.
  - In REQ with addr_ok, or in WAIT without data_ok: go to DRAIN.
  - In WAIT with data_ok, or in REQ with addr_ok and data_ok in the same cycle: go to IDLE.
  - In DRAIN: remain in DRAIN; the held instruction is already discarded.
- DRAIN: no outputs valid, data_req=0. data_ok leads to IDLE and its data is discarded.
- Reset mid-transaction abandons any outstanding response; the SRAM side is reset together with this block.

Test Plan:
- lh at addr 0x1002, rdata 0x8001_7FFF, addr_ok and data_ok one cycle apart -> data_size=1, wb_rf_wdata=0xFFFF_8001, wb_valid 3 cycles after accept.
- sb at addr 0x2003 with wdata 0x0000_00A5 -> data_wstrb=1000, data_wdata=0xA5A5_A5A5, data_wr=1; at WB wb_rf_we=0.
- lw at addr 0x3002 -> data_req never asserts; wb_exc_ale=1 and wb_rf_we=0 one cycle after accept.
- Back-to-back: lbu at 0x11 then ALU op (ex_result 0x1234) with wb_ready=1 and rdata 0x0000_C300 -> lbu result 0x0000_00C3, then 0x1234 on consecutive cycles. fwd_pending=1 during REQ/WAIT of the lbu.
- Flush in WAIT for lw, data_ok 4 cycles later with 0xDEADBEEF -> DRAIN, wb_valid stays 0, ex_ready=0 until the cycle after data_ok, data discarded.
- addr_ok held 0 for 5 cycles -> data_req, data_addr and data_wstrb stable throughout; rst asserted in WAIT -> next cycle all outputs 0, ex_ready=1.
